// File: rtl/cast_arbiter_pkg.sv
// Purpose : shared types for the cast arbiter (cast kind, output-register FSM state).
// Latency : n/a (types only).
// Backpr. : n/a (types only).
package cast_arbiter_pkg;

    typedef enum logic {
        CAST_ZERO = 1'b0,
        CAST_SIGN = 1'b1
    } cast_kind_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/cast_unit.sv
// Purpose : combinational resize of one value from IN_WIDTH to OUT_WIDTH bits.
// Latency : 0 cycles (pure combinational).
// Backpr. : none; the result follows the inputs.
//
// Ports: data (IN_WIDTH value), kind (zero/sign), result (OUT_WIDTH value).
// Widening zero- or sign-extends according to kind. Narrowing truncates and
// ignores kind, unless CAST_ARBITER_SATURATE_EN is defined, in which case the
// value clamps to the unsigned (CAST_ZERO) or signed (CAST_SIGN) output range.
module cast_unit
    import cast_arbiter_pkg::*;
#(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 4
) (
    input  logic [IN_WIDTH-1:0]  data,
    input  cast_kind_t           kind,
    output logic [OUT_WIDTH-1:0] result
);

    generate
        if (OUT_WIDTH == IN_WIDTH) begin : g_same
            logic unused_kind;
            assign unused_kind = kind;
            assign result      = data;
        end else if (OUT_WIDTH > IN_WIDTH) begin : g_widen
            logic fill;
            assign fill   = (kind == CAST_SIGN) & data[IN_WIDTH-1];
            assign result = {{(OUT_WIDTH-IN_WIDTH){fill}}, data};
        end else begin : g_narrow
`ifdef CAST_ARBITER_SATURATE_EN
            logic [OUT_WIDTH-1:0] s_min;
            logic [OUT_WIDTH-1:0] s_max;
            always_comb begin
                s_min                = '0;
                s_min[OUT_WIDTH-1]   = 1'b1;
                s_max                = ~s_min;
                result               = data[OUT_WIDTH-1:0];
                if (kind == CAST_SIGN) begin
                    // Fits the signed output range only when every bit from the
                    // input sign down to the output sign position agrees.
                    if (!(&data[IN_WIDTH-1:OUT_WIDTH-1]) && (|data[IN_WIDTH-1:OUT_WIDTH-1])) begin
                        result = data[IN_WIDTH-1] ? s_min : s_max;
                    end
                end else if (|data[IN_WIDTH-1:OUT_WIDTH]) begin
                    result = '1;
                end
            end
`else
            logic unused_narrow;
            assign unused_narrow = ^{kind, data[IN_WIDTH-1:OUT_WIDTH]};
            assign result        = data[OUT_WIDTH-1:0];
`endif
        end
    endgenerate

endmodule

// File: rtl/cast_arbiter.sv
// Purpose : round-robin arbiter sharing one width-cast unit among N_REQ requesters.
// Latency : 1 cycle from accept (o_req_ready) to o_valid with the cast result.
// Backpr. : while the output register is full and i_ready is low, no request is accepted.
//
// Ports: i_clk, i_rst_n (sync, active-low); i_req_valid/i_req_data/i_req_kind per
// requester with o_req_ready (one-hot or zero); o_valid/o_data/o_src/i_ready to consumer.
// Optional feature: CAST_ARBITER_SATURATE_EN (clamp instead of truncate on narrowing).
module cast_arbiter
    import cast_arbiter_pkg::*;
#(
    parameter  int N_REQ     = 2,
    parameter  int IN_WIDTH  = 8,
    parameter  int OUT_WIDTH = 4,
    localparam int SRC_W     = $clog2(N_REQ)
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic       [N_REQ-1:0]             i_req_valid,
    input  logic       [N_REQ-1:0][IN_WIDTH-1:0] i_req_data,
    input  cast_kind_t [N_REQ-1:0]             i_req_kind,
    output logic       [N_REQ-1:0]             o_req_ready,
    output logic                               o_valid,
    output logic       [OUT_WIDTH-1:0]         o_data,
    output logic       [SRC_W-1:0]             o_src,
    input  logic                               i_ready
);

    state_t               state;
    state_t               state_nxt;
    logic [SRC_W-1:0]     rr_ptr;
    logic [SRC_W-1:0]     grant;
    logic                 load;
    logic [IN_WIDTH-1:0]  sel_data;
    cast_kind_t           sel_kind;
    logic [OUT_WIDTH-1:0] cast_res;

    // A new request can enter when the register is empty or is being drained
    // this same cycle; reset blocks acceptance so nothing leaks through it.
    assign load = (|i_req_valid) && (state == EMPTY || i_ready) && i_rst_n;

    // First valid requester at or after rr_ptr, wrapping at N_REQ-1.
    always_comb begin
        int  scan_idx;
        logic found;
        grant    = rr_ptr;
        found    = 1'b0;
        scan_idx = 0;
        for (int i = 0; i < N_REQ; i++) begin
            scan_idx = (int'(rr_ptr) + i) % N_REQ;
            if (!found && i_req_valid[SRC_W'(scan_idx)]) begin
                grant = SRC_W'(scan_idx);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        o_req_ready = '0;
        if (load) begin
            o_req_ready[grant] = 1'b1;
        end
    end

    assign sel_data = i_req_data[grant];
    assign sel_kind = i_req_kind[grant];

    cast_unit #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_cast (
        .data   (sel_data),
        .kind   (sel_kind),
        .result (cast_res)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (load) state_nxt = FULL;
            FULL: begin
                if (load) begin
                    state_nxt = FULL;
                end else if (i_ready) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Output register and priority pointer only move on an accepted request;
    // a plain drain leaves o_data/o_src holding the last result.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_data <= '0;
            o_src  <= '0;
            rr_ptr <= '0;
        end else if (load) begin
            o_data <= cast_res;
            o_src  <= grant;
            rr_ptr <= (grant == SRC_W'(N_REQ - 1)) ? '0 : grant + SRC_W'(1);
        end
    end

    assign o_valid = (state == FULL);

endmodule

// File: tb/tb_cast_arbiter.sv
// Purpose : self-checking bench for cast_arbiter (2x8->4 instance plus 3x8->12 instance).
// Latency : reference model predicts results one cycle after each accepted request.
// Backpr. : consumer ready is driven directly and randomised in the soak phase.
`timescale 1ns/1ps
module tb_cast_arbiter;
    import cast_arbiter_pkg::*;

    localparam int NA  = 2;
    localparam int INW = 8;
    localparam int OA  = 4;
    localparam int NB  = 3;
    localparam int OB  = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       [NA-1:0]          vld_a;
    logic       [NA-1:0][INW-1:0] dat_a;
    cast_kind_t [NA-1:0]          kind_a;
    logic       [NA-1:0]          rdy_a;
    logic                         ovld_a;
    logic       [OA-1:0]          odat_a;
    logic       [0:0]             osrc_a;
    logic                         cons_a;

    logic       [NB-1:0]          vld_b;
    logic       [NB-1:0][INW-1:0] dat_b;
    cast_kind_t [NB-1:0]          kind_b;
    logic       [NB-1:0]          rdy_b;
    logic                         ovld_b;
    logic       [OB-1:0]          odat_b;
    logic       [1:0]             osrc_b;
    logic                         cons_b;

    cast_arbiter #(.N_REQ(NA), .IN_WIDTH(INW), .OUT_WIDTH(OA)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(vld_a), .i_req_data(dat_a),
        .i_req_kind(kind_a), .o_req_ready(rdy_a), .o_valid(ovld_a), .o_data(odat_a),
        .o_src(osrc_a), .i_ready(cons_a)
    );

    cast_arbiter #(.N_REQ(NB), .IN_WIDTH(INW), .OUT_WIDTH(OB)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(vld_b), .i_req_data(dat_b),
        .i_req_kind(kind_b), .o_req_ready(rdy_b), .o_valid(ovld_b), .o_data(odat_b),
        .o_src(osrc_b), .i_ready(cons_b)
    );

    int checks = 0;
    int errors = 0;

    // Reference state for dut_a: output register contents and the requester
    // that currently has first priority.
    bit          m_full;
    int          m_data;
    int          m_src;
    int          m_rr;
    logic [NA-1:0] acc_a;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [NA-1:0] v, input int rr);
        for (int i = 0; i < NA; i++) begin
            if (v[(rr + i) % NA]) return (rr + i) % NA;
        end
        return -1;
    endfunction

    function automatic int cast_ref(input int v, input bit sgn, input int in_w, input int out_w);
        int sv;
        int lo;
        int hi;
        sv = (sgn && v >= (1 << (in_w - 1))) ? v - (1 << in_w) : v;
        lo = -(1 << (out_w - 1));
        hi = (1 << (out_w - 1)) - 1;
        if (out_w >= in_w) return sgn ? ((sv < 0) ? sv + (1 << out_w) : sv) : v;
`ifdef CAST_ARBITER_SATURATE_EN
        if (!sgn) return (v > (1 << out_w) - 1) ? (1 << out_w) - 1 : v;
        if (sv < lo) sv = lo;
        if (sv > hi) sv = hi;
        return (sv < 0) ? sv + (1 << out_w) : sv;
`else
        return v % (1 << out_w);
`endif
    endfunction

    // One clock of dut_a: check grant before the edge, advance the model, check the register after.
    task automatic tick();
        int          g;
        bit          ld;
        logic [NA-1:0] exp_rdy;
        #1;
        g       = pick(vld_a, m_rr);
        ld      = rst_n && (g >= 0) && (!m_full || cons_a);
        exp_rdy = '0;
        if (ld) exp_rdy[g] = 1'b1;
        check("ready_a", 32'(rdy_a), 32'(exp_rdy));
        acc_a = rdy_a;
        @(posedge clk);
        if (!rst_n) begin
            m_full = 0; m_data = 0; m_src = 0; m_rr = 0;
        end else if (ld) begin
            m_data = cast_ref(int'(dat_a[g]), kind_a[g] == CAST_SIGN, INW, OA);
            m_src  = g;
            m_full = 1;
            m_rr   = (g + 1) % NA;
        end else if (m_full && cons_a) begin
            m_full = 0;
        end
        @(negedge clk);
        check("valid_a", 32'(ovld_a), 32'(m_full));
        check("data_a", 32'(odat_a), m_data);
        check("src_a", 32'(osrc_a), m_src);
    endtask

    initial begin
        int exp5 [3];
        logic [INW-1:0] d5 [3];
        cast_kind_t k5 [3];

        m_full = 0; m_data = 0; m_src = 0; m_rr = 0; acc_a = '0;
        rst_n  = 1'b0;
        vld_a  = 2'b11; dat_a[0] = 8'h35; dat_a[1] = 8'h4A;
        kind_a[0] = CAST_ZERO; kind_a[1] = CAST_ZERO; cons_a = 1'b1;
        vld_b  = '0; dat_b = '0; kind_b[0] = CAST_ZERO; kind_b[1] = CAST_ZERO;
        kind_b[2] = CAST_ZERO; cons_b = 1'b1;

        // Reset held with requests pending.
        @(negedge clk);
        tick();
        tick();
        check("rst_valid", 32'(ovld_a), 32'd0);
        check("rst_data", 32'(odat_a), 32'd0);
        check("rst_ready", 32'(rdy_a), 32'd0);
        check("rst_valid_b", 32'(ovld_b), 32'd0);

        // Release: requester 0 first, then strict alternation at full rate.
        rst_n = 1'b1;
        #1 check("first_grant", 32'(rdy_a), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("alt_src", 32'(osrc_a), i % 2);
            check("alt_data", 32'(odat_a), (i % 2) ? 32'hA : 32'h5);
        end

        // Backpressure: register and priority frozen, no grants.
        cons_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_data", 32'(odat_a), 32'hA);
            check("bp_src", 32'(osrc_a), 32'd1);
        end
        cons_a = 1'b1;
        tick();
        check("bp_release_src", 32'(osrc_a), 32'd0);
        check("bp_release_data", 32'(odat_a), 32'h5);
        tick();

        // Narrowing casts on requester 0 alone.
`ifdef CAST_ARBITER_SATURATE_EN
        exp5[0] = 'hF; exp5[1] = 'h8; exp5[2] = 'h5;
`else
        exp5[0] = 'hC; exp5[1] = 'hC; exp5[2] = 'h5;
`endif
        d5[0] = 8'h9C; d5[1] = 8'h9C; d5[2] = 8'h05;
        k5[0] = CAST_ZERO; k5[1] = CAST_SIGN; k5[2] = CAST_SIGN;
        vld_a = 2'b01;
        for (int i = 0; i < 3; i++) begin
            dat_a[0] = d5[i]; kind_a[0] = k5[i];
            tick();
            check("narrow_cast", 32'(odat_a), exp5[i]);
        end
        vld_a = 2'b00;

        // Three requesters, widening: lone req2 with pointer at 0, then wrap to 0.
        vld_b = 3'b100; dat_b[2] = 8'h9C; kind_b[2] = CAST_SIGN;
        #1 check("b_grant2", 32'(rdy_b), 32'b100);
        tick();
        check("b_valid", 32'(ovld_b), 32'd1);
        check("b_src2", 32'(osrc_b), 32'd2);
        check("b_sign_ext", 32'(odat_b), 32'hF9C);
        vld_b = 3'b011; dat_b[0] = 8'h9C; kind_b[0] = CAST_ZERO;
        dat_b[1] = 8'h11; kind_b[1] = CAST_SIGN;
        #1 check("b_wrap_grant0", 32'(rdy_b), 32'b001);
        tick();
        check("b_zero_ext", 32'(odat_b), 32'h09C);
        check("b_src0", 32'(osrc_b), 32'd0);
        vld_b = 3'b010;
        #1 check("b_grant1", 32'(rdy_b), 32'b010);
        tick();
        check("b_data1", 32'(odat_b), 32'h011);
        vld_b = 3'b000;
        tick();
        check("b_drain_valid", 32'(ovld_b), 32'd0);
        check("b_drain_hold", 32'(odat_b), 32'h011);

        // Random soak on dut_a: requesters hold until accepted, random consumer and resets.
        acc_a = '0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NA; i++) begin
                if (!vld_a[i] || acc_a[i]) begin
                    vld_a[i]  = ($urandom_range(0, 2) != 0);
                    dat_a[i]  = INW'($urandom_range(0, 255));
                    kind_a[i] = cast_kind_t'($urandom_range(0, 1));
                end
            end
            cons_a = ($urandom_range(0, 3) != 0);
            rst_n  = ($urandom_range(0, 63) != 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
